// File: rtl/idli_sqi_mem_bank_m.sv
// ---------------------------------------------------------------------------
// idli_sqi_mem_bank_m
//
// Parametrised SQI serial SRAM model (23LC1024-style quad command set) for the
// FPGA bench. Everything runs on the bench global clock; the SQI serial clock
// is oversampled and its edges are detected against a registered copy.
// Supported commands: READ (0x03), WRITE (0x02), RDMR (0x05), WRMR (0x01).
// Byte, page and sequential addressing modes.
//
// Ports:
//   i_sqi_gck     bench global clock
//   i_sqi_rst     synchronous active-high reset
//   i_sqi_sck     SQI serial clock (synchronous to gck, >=1 gck high/low)
//   i_sqi_cs      chip select, active low
//   i_sqi_sio     nibble from master (sampled on sck rise)
//   o_sqi_sio     nibble to master (updated on sck fall)
//   o_sqi_sio_en  high while o_sqi_sio carries data
//   o_sqi_mode    current mode register (00 byte, 10 page, 01 sequential)
//   o_sqi_err     sticky error: unsupported command or reserved mode write
//
// Storage (data_q) is never reset; it may be preloaded through a
// hierarchical reference from the bench.
// ---------------------------------------------------------------------------
module idli_sqi_mem_bank_m #(
  parameter int         ADDR_W        = 17,
  parameter int         ADDR_NIBBLES  = 6,
  parameter int         DUMMY_NIBBLES = 2,
  parameter int         PAGE_BYTES    = 32,
  parameter logic [1:0] INIT_MODE     = 2'b01
) (
  input  logic       i_sqi_gck,
  input  logic       i_sqi_rst,
  input  logic       i_sqi_sck,
  input  logic       i_sqi_cs,
  input  logic [3:0] i_sqi_sio,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_sio_en,
  output logic [1:0] o_sqi_mode,
  output logic       o_sqi_err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // Page mode keeps the bits above the page offset fixed.
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_BYTES - 1);

  localparam logic [3:0] ADDR_LAST  = 4'(ADDR_NIBBLES - 1);
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);
  // RDMR always has two turnaround nibbles, independent of DUMMY_NIBBLES.
  localparam logic [3:0] RDMR_DUMMY = 4'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_WR,
    ST_RDMR,
    ST_WRMR,
    ST_IGNORE
  } state_e;

  // Pointer advance after a complete byte, according to the addressing mode.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [1:0]        mode,
                                                 input logic [ADDR_W-1:0] ptr);
    logic [ADDR_W-1:0] inc;
    inc = ptr + ADDR_W'(1'b1);
    case (mode)
      MODE_BYTE: next_ptr = ptr;
      MODE_PAGE: next_ptr = (ptr & ~PAGE_MASK) | (inc & PAGE_MASK);
      default:   next_ptr = inc;
    endcase
  endfunction

  logic [7:0]        data_q [DEPTH];

  state_e            state_q, state_d;
  logic              sck_q;
  logic              cs_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              half_q, half_d;
  logic [3:0]        hi_q, hi_d;
  logic              done_q, done_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        mode_q, mode_d;
  logic              err_q, err_d;
  logic [3:0]        sio_q, sio_d;
  logic              sio_en_q, sio_en_d;

  logic              rise_s;
  logic              fall_s;
  logic [7:0]        rd_byte_s;
  logic              mem_we_s;
  logic [7:0]        mem_wdata_s;

  assign rise_s    = i_sqi_sck & ~sck_q;
  assign fall_s    = ~i_sqi_sck & sck_q;
  assign rd_byte_s = data_q[ptr_q];

  assign o_sqi_sio    = sio_q;
  assign o_sqi_sio_en = sio_en_q;
  assign o_sqi_mode   = mode_q;
  assign o_sqi_err    = err_q;

  // Next-state, datapath and output decode for the command FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    hi_d        = hi_q;
    done_d      = done_q;
    is_rd_d     = is_rd_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    err_d       = err_q;
    sio_d       = sio_q;
    sio_en_d    = sio_en_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = {hi_q, i_sqi_sio};

    if (i_sqi_cs) begin
      // Deselect wins over any sck edge in the same gck; a lone high
      // nibble of a write byte is simply dropped with half_q.
      state_d  = ST_IDLE;
      sio_en_d = 1'b0;
      half_d   = 1'b0;
      cnt_d    = 4'd0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_q) begin
            state_d = ST_CMD;
            half_d  = 1'b0;
            cnt_d   = 4'd0;
            done_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CMD: begin
          if (rise_s) begin
            if (!half_q) begin
              hi_d   = i_sqi_sio;
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              cnt_d  = 4'd0;
              case ({hi_q, i_sqi_sio})
                8'h03: begin
                  state_d = ST_ADDR;
                  is_rd_d = 1'b1;
                end
                8'h02: begin
                  state_d = ST_ADDR;
                  is_rd_d = 1'b0;
                end
                8'h05:   state_d = ST_RDMR;
                8'h01:   state_d = ST_WRMR;
                default: begin
                  state_d = ST_IGNORE;
                  err_d   = 1'b1;
                end
              endcase
            end
          end else begin
            state_d = ST_CMD;
          end
        end

        ST_ADDR: begin
          if (rise_s) begin
            // Shift MSB-nibble-first; bits above ADDR_W fall off the top.
            ptr_d = (ptr_q << 3'd4) | ADDR_W'(i_sqi_sio);
            if (cnt_q == ADDR_LAST) begin
              cnt_d = 4'd0;
              if (!is_rd_q) begin
                state_d = ST_WR;
              end else if (DUMMY_NIBBLES == 0) begin
                state_d = ST_RD;
              end else begin
                state_d = ST_DUMMY;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        ST_DUMMY: begin
          if (rise_s) begin
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 4'd0;
              state_d = ST_RD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_DUMMY;
          end
        end

        ST_RD: begin
          if (fall_s) begin
            sio_en_d = 1'b1;
            if (done_q) begin
              // Byte mode after the first byte: nothing left to read.
              sio_d = 4'h0;
            end else if (!half_q) begin
              sio_d  = rd_byte_s[7:4];
              half_d = 1'b1;
            end else begin
              sio_d  = rd_byte_s[3:0];
              half_d = 1'b0;
              ptr_d  = next_ptr(mode_q, ptr_q);
              done_d = (mode_q == MODE_BYTE);
            end
          end else begin
            state_d = ST_RD;
          end
        end

        ST_WR: begin
          if (rise_s && !done_q) begin
            if (!half_q) begin
              hi_d   = i_sqi_sio;
              half_d = 1'b1;
            end else begin
              mem_we_s = 1'b1;
              half_d   = 1'b0;
              ptr_d    = next_ptr(mode_q, ptr_q);
              done_d   = (mode_q == MODE_BYTE);
            end
          end else begin
            state_d = ST_WR;
          end
        end

        ST_RDMR: begin
          if (cnt_q < RDMR_DUMMY) begin
            if (rise_s) begin
              cnt_d = cnt_q + 4'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end else if (fall_s) begin
            sio_en_d = 1'b1;
            sio_d    = half_q ? 4'h0 : {mode_q, 2'b00};
            half_d   = ~half_q;
          end else begin
            state_d = ST_RDMR;
          end
        end

        ST_WRMR: begin
          if (rise_s && !done_q) begin
            if (!half_q) begin
              hi_d   = i_sqi_sio;
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              done_d = 1'b1;
              // Mode bits are [7:6] of the byte, i.e. the top of the first nibble.
              if (hi_q[3:2] == MODE_RSVD) begin
                err_d = 1'b1;
              end else begin
                mode_d = hi_q[3:2];
              end
            end
          end else begin
            state_d = ST_WRMR;
          end
        end

        ST_IGNORE: state_d = ST_IGNORE;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control/state registers, edge-detect flops and registered outputs.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q  <= ST_IDLE;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      cnt_q    <= 4'd0;
      half_q   <= 1'b0;
      hi_q     <= 4'h0;
      done_q   <= 1'b0;
      is_rd_q  <= 1'b0;
      ptr_q    <= {ADDR_W{1'b0}};
      mode_q   <= INIT_MODE;
      err_q    <= 1'b0;
      sio_q    <= 4'h0;
      sio_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sck_q    <= i_sqi_sck;
      cs_q     <= i_sqi_cs;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
      is_rd_q  <= is_rd_d;
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      sio_q    <= sio_d;
      sio_en_q <= sio_en_d;
    end
  end

  // Byte storage write port; reset suppresses a write but never clears contents.
  always_ff @(posedge i_sqi_gck) begin
    if (mem_we_s && !i_sqi_rst) begin
      data_q[ptr_q] <= mem_wdata_s;
    end
  end

endmodule
